cascade_down_timer: RTL and testbench
=====================================

# cascade_down_timer

Parametrised multi-digit down-counter for the oven time display and cook timer. It chains DIGITS modulo-N digit stages through a borrow chain, supports parallel load and a registered zero flag, and generates a one-cycle done pulse when counting reaches zero. A WRAP mode selects stop-at-zero or roll-over behaviour. It sits between the keypad or time-entry logic (load path) and the display decoder and cook-control FSM (Dout, zero, done).

## Interface
- DIGITS, 4: number of digit stages; digit 0 is least significant.
- DW, 4: bits per digit.
- MODS, 16'hAA6A: packed per-digit modulus, DW bits per digit, digit 0 in LSBs. The default gives MM:SS (10, 6, 10, 10). Each modulus must be in the range 2..2^DW.
- WRAP, 0: selects the behaviour at all-zero. 0 holds at all-zero; 1 rolls over to the maximum value.

Ports:
- clock  in  1: rising-edge clock.
- clrn  in  1: reset, asynchronous, active-low.
- loadn  in  1: synchronous parallel load, active-low.
- en  in  1: count tick; the counter decrements once per clock while en is high.
- data  in  DIGITS*DW: load value, packed the same way as MODS.
- Dout  out  DIGITS*DW: current count, registered.
- zero  out  1: registered; high exactly when Dout is all-zero.
- done  out  1: registered; one-cycle pulse on a count-driven transition to all-zero.
- tc  out  1: combinational; en & zero. This is the cascade borrow-out to a further timer.

## Operation
- Priority is clrn, then loadn, then en, then hold.
- Reset (clrn=0), asynchronous: Dout=0, zero=1, done=0. tc then follows en.
- Load (loadn=0):
  - Each digit i takes data digit i.
  - Any data digit ≥ MODS[i] saturates to MODS[i]-1.
  - zero is set to whether the resulting value is all-zero.
  - done=0.
  - en is ignored in the load cycle.
- Count (en=1, loadn=1):
  - Borrow into digit 0 is 1. Borrow into digit i+1 is borrow_i & (digit i == 0).
  - A digit receiving borrow decrements. If it is 0, it reloads MODS[i]-1.
- All-zero with en=1:
  - WRAP=0: Dout holds, zero stays 1, done=0.
  - WRAP=1: every digit becomes MODS[i]-1, and zero falls.
- done=1 for exactly the cycle after Dout goes from value 1 (digit 0 = 1, all others 0) to all-zero by counting. It is 0 in every other cycle, including after load of 0 and after reset.
- Idle (en=0, loadn=1): all registers hold, and done returns to 0.

## Timing
- Load and count take effect at the next rising clock edge. Dout, zero and done all update on that same edge.
- tc has zero latency from en. It is valid in the same cycle for a downstream timer's en.
- Reset assertion mid-count clears immediately, with no clock required. Deassertion is synchronised externally.
- Back-to-back en pulses decrement once per cycle. No minimum spacing.
- If loadn and en are both low/high in the same cycle, the load wins and no decrement is applied.

## Structure
- Shared package or header `timer_pkg`: digit width default, default MODS for MM:SS, and a function that extracts digit i's modulus from MODS.
- Sub-module `modn_digit` (one per digit, via generate):
  - Parameter: MOD.
  - Inputs: clock, clrn, load, ld_val, borrow_in.
  - Outputs: q, is_zero, borrow_out.
  - Holds the per-digit saturation and wrap logic.
- The top level contains the borrow chain, the zero register, done generation, the WRAP=0 all-zero inhibit, and tc.

## Test plan
- Reset: assert clrn mid-count with Dout=0x0130 → Dout=0, zero=1, done=0 immediately, without a clock.
- Load 0x0130 (01:30), then 1 en cycle → 0x0129. After 90 en cycles: Dout=0x0000, zero=1, done high for one cycle. A further en gives no change (WRAP=0).
- Load 0x1000, then 1 en cycle → 0x0959, showing the borrow across all digits with the tens-of-seconds stage wrapping to 5.
- Load 0x0A7F → saturates to 0x0959. Load 0x0000 → zero=1, done stays 0.
- WRAP=1: load 0x0001, then 2 en cycles → 0x0000 (done pulse), then 0x9959 with zero=0. tc=1 only while en=1 at all-zero.
- loadn=0 and en=1 together with data=0x0005 → Dout=0x0005 with no decrement. Next en → 0x0004.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded down-timer digit chain.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//   DIGIT_W    : default bits per digit
//   MODS_MMSS  : packed per-digit moduli for an MM:SS display (10, 6, 10, 10)
//   digit_mod(): extracts one digit's modulus from a packed MODS word
package timer_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [15:0] MODS_MMSS = 16'hAA6A;

    // A modulus of exactly 2^dw cannot be written in dw bits, so an all-zero
    // field stands for 2^dw (a plain binary digit).
    function automatic int digit_mod(input logic [63:0] mods, input int idx, input int dw);
        logic [63:0] field;
        field = (mods >> (idx * dw)) & ((64'd1 << dw) - 64'd1);
        return (field == 64'd0) ? (1 << dw) : int'(field);
    endfunction

endpackage

// File: rtl/cascade_down_timer_if.sv
// Load/count/status bundle between the time-entry logic and the down-timer.
// Latency: n/a (signal grouping only).
// Backpressure: none; en is a plain per-cycle tick, tc is the borrow-out.
//   master : drives loadn, en, data; observes Dout, zero, done, tc
//   slave  : the timer itself
interface cascade_down_timer_if #(
    parameter int DIGITS = 4,
    parameter int DW     = 4
);
    logic                   loadn;
    logic                   en;
    logic [DIGITS*DW-1:0]   data;
    logic [DIGITS*DW-1:0]   Dout;
    logic                   zero;
    logic                   done;
    logic                   tc;

    modport master (output loadn, en, data, input Dout, zero, done, tc);
    modport slave  (input loadn, en, data, output Dout, zero, done, tc);
endinterface

// File: rtl/modn_digit.sv
// One modulo-MOD down-counting digit with saturating parallel load.
// Latency: q updates on the clock edge after load or borrow_in.
// Backpressure: none; borrow_out is combinational from borrow_in and q.
//   clock, clrn      : clock, async active-low reset (q -> 0)
//   load, ld_val     : parallel load; values >= MOD clamp to MOD-1
//   borrow_in        : decrement request; 0 reloads MOD-1
//   q, is_zero       : current digit and its zero flag
//   borrow_out       : borrow to the next more significant digit
module modn_digit #(
    parameter int DW  = 4,
    parameter int MOD = 10
) (
    input  logic          clock,
    input  logic          clrn,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    input  logic          borrow_in,
    output logic [DW-1:0] q,
    output logic          is_zero,
    output logic          borrow_out
);
    localparam int          MOD_M1 = MOD - 1;
    localparam logic [DW:0] MOD_W  = MOD[DW:0];
    localparam logic [DW-1:0] MAX_V = MOD_M1[DW-1:0];

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_ld_sat;

    // Compare with one extra bit so a modulus of 2^DW never saturates.
    assign w_ld_sat = ({1'b0, ld_val} >= MOD_W) ? MAX_V : ld_val;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_ld_sat;
        end else if (borrow_in) begin
            r_q <= (r_q == '0) ? MAX_V : r_q - DW'(1);
        end
    end

    assign q          = r_q;
    assign is_zero    = (r_q == '0);
    assign borrow_out = borrow_in & is_zero;
endmodule

// File: rtl/cascade_down_timer.sv
// Multi-digit cascaded down-counter with load, zero flag, done pulse and tc.
// Latency: Dout/zero/done update one clock after load or en; tc is same-cycle.
// Backpressure: none; with WRAP=0 an en at all-zero is absorbed (count holds).
//   clock, clrn : clock, async active-low reset (Dout=0, zero=1, done=0)
//   bus         : slave side of cascade_down_timer_if (loadn, en, data in;
//                 Dout, zero, done, tc out)
module cascade_down_timer
    import timer_pkg::*;
#(
    parameter int                   DIGITS = 4,
    parameter int                   DW     = DIGIT_W,
    parameter logic [DIGITS*DW-1:0] MODS   = MODS_MMSS,
    parameter bit                   WRAP   = 1'b0
) (
    input  logic                 clock,
    input  logic                 clrn,
    cascade_down_timer_if.slave  bus
);
    logic [DW-1:0]        w_q [DIGITS];
    logic [DIGITS:0]      w_borrow;
    logic [DIGITS-1:0]    w_dig_zero;
    logic [DIGITS*DW-1:0] w_dout;
    logic                 w_load;
    logic                 w_cnt;
    logic                 w_is_one;
    logic                 w_wrap;
    logic                 r_zero;
    logic                 r_done;

    assign w_load = ~bus.loadn;
    // Load wins over en; in hold mode an all-zero count swallows the tick.
    assign w_cnt       = bus.loadn & bus.en & (WRAP | ~r_zero);
    assign w_borrow[0] = w_cnt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        modn_digit #(
            .DW  (DW),
            .MOD (digit_mod(64'(MODS), i, DW))
        ) u_digit (
            .clock      (clock),
            .clrn       (clrn),
            .load       (w_load),
            .ld_val     (bus.data[i*DW +: DW]),
            .borrow_in  (w_borrow[i]),
            .q          (w_q[i]),
            .is_zero    (w_dig_zero[i]),
            .borrow_out (w_borrow[i+1])
        );
        assign w_dout[i*DW +: DW] = w_q[i];
    end

    // Count value 1: digit 0 is one and every upper digit is zero.
    assign w_is_one = (w_q[0] == DW'(1)) & (&(w_dig_zero | DIGITS'(1)));
    // Borrow out of the top digit only happens when counting from all-zero.
    assign w_wrap   = w_borrow[DIGITS];

    // zero is tracked as the next-state of "Dout == 0" so it lands on the
    // same edge as the digits. Saturation never turns a non-zero digit into
    // zero, so on load the raw data decides it.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_zero <= 1'b1;
            r_done <= 1'b0;
        end else if (w_load) begin
            r_zero <= (bus.data == '0);
            r_done <= 1'b0;
        end else if (w_cnt) begin
            r_zero <= w_is_one | (r_zero & ~w_wrap);
            r_done <= w_is_one;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bus.Dout = w_dout;
    assign bus.zero = r_zero;
    assign bus.done = r_done;
    assign bus.tc   = bus.en & r_zero;
endmodule

// File: tb/tb_cascade_down_timer.sv
// Directed bench for cascade_down_timer: one hold-at-zero and one wrapping
// instance driven with identical stimulus, checked against hand-computed values.
module tb_cascade_down_timer;

    logic clock = 1'b0;
    logic clrn;

    always #5 clock = ~clock;

    cascade_down_timer_if #(.DIGITS(4), .DW(4)) bus0 ();
    cascade_down_timer_if #(.DIGITS(4), .DW(4)) bus1 ();

    cascade_down_timer #(.DIGITS(4), .DW(4), .MODS(16'hAA6A), .WRAP(1'b0)) u_hold (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus0)
    );

    cascade_down_timer #(.DIGITS(4), .DW(4), .MODS(16'hAA6A), .WRAP(1'b1)) u_wrap (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus1)
    );

    int n_chk = 0;
    int n_bad = 0;
    int n_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ld_n, input logic e, input logic [15:0] d);
        bus0.loadn = ld_n; bus0.en = e; bus0.data = d;
        bus1.loadn = ld_n; bus1.en = e; bus1.data = d;
    endtask

    task automatic chk0(input string tag, input logic [15:0] d, input logic z, input logic dn);
        chk({tag, " hold.Dout"}, 32'(bus0.Dout), 32'(d));
        chk({tag, " hold.zero"}, 32'(bus0.zero), 32'(z));
        chk({tag, " hold.done"}, 32'(bus0.done), 32'(dn));
    endtask

    task automatic chk1(input string tag, input logic [15:0] d, input logic z, input logic dn);
        chk({tag, " wrap.Dout"}, 32'(bus1.Dout), 32'(d));
        chk({tag, " wrap.zero"}, 32'(bus1.zero), 32'(z));
        chk({tag, " wrap.done"}, 32'(bus1.done), 32'(dn));
    endtask

    initial begin
        clrn = 1'b0;
        drive(1'b1, 1'b0, 16'h0000);
        repeat (2) tick();
        clrn = 1'b1;
        tick();
        chk0("reset", 16'h0000, 1'b1, 1'b0);
        chk1("reset", 16'h0000, 1'b1, 1'b0);
        chk("reset tc idle", 32'(bus0.tc), 32'd0);
        bus0.en = 1'b1; bus1.en = 1'b1;
        #1;
        chk("tc follows en hold", 32'(bus0.tc), 32'd1);
        chk("tc follows en wrap", 32'(bus1.tc), 32'd1);
        drive(1'b1, 1'b0, 16'h0000);

        // 01:30 counted all the way down
        drive(1'b0, 1'b0, 16'h0130);
        tick();
        chk0("load 0130", 16'h0130, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0000);
        tick();
        chk0("first dec", 16'h0129, 1'b0, 1'b0);
        chk1("first dec", 16'h0129, 1'b0, 1'b0);
        n_done = 0;
        repeat (88) begin
            tick();
            if (bus0.done) n_done++;
        end
        chk("no early done", 32'(n_done), 32'd0);
        chk0("at one", 16'h0001, 1'b0, 1'b0);
        tick();
        chk0("reach zero", 16'h0000, 1'b1, 1'b1);
        chk1("reach zero", 16'h0000, 1'b1, 1'b1);
        tick();
        chk0("hold at zero", 16'h0000, 1'b1, 1'b0);
        chk("tc at zero hold", 32'(bus0.tc), 32'd1);
        chk1("roll over", 16'h9959, 1'b0, 1'b0);
        chk("tc after roll", 32'(bus1.tc), 32'd0);
        drive(1'b1, 1'b0, 16'h0000);

        // asynchronous clear while counting is enabled
        drive(1'b0, 1'b0, 16'h0130);
        tick();
        drive(1'b1, 1'b1, 16'h0000);
        #2 clrn = 1'b0;
        #1;
        chk0("async clr", 16'h0000, 1'b1, 1'b0);
        chk1("async clr", 16'h0000, 1'b1, 1'b0);
        chk("tc in clr", 32'(bus0.tc), 32'd1);
        drive(1'b1, 1'b0, 16'h0000);
        clrn = 1'b1;
        tick();
        chk0("after clr", 16'h0000, 1'b1, 1'b0);

        // borrow through every digit
        drive(1'b0, 1'b0, 16'h1000);
        tick();
        drive(1'b1, 1'b1, 16'h0000);
        tick();
        chk0("borrow all", 16'h0959, 1'b0, 1'b0);
        chk1("borrow all", 16'h0959, 1'b0, 1'b0);

        // load saturation and load of zero
        drive(1'b0, 1'b0, 16'h0A7F);
        tick();
        chk0("saturate", 16'h0959, 1'b0, 1'b0);
        chk1("saturate", 16'h0959, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0001);
        tick();
        chk0("load one", 16'h0001, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk0("load zero", 16'h0000, 1'b1, 1'b0);
        chk1("load zero", 16'h0000, 1'b1, 1'b0);

        // 0001 -> 0000 -> wrap/hold
        drive(1'b0, 1'b0, 16'h0001);
        tick();
        drive(1'b1, 1'b1, 16'h0000);
        tick();
        chk0("one to zero", 16'h0000, 1'b1, 1'b1);
        chk1("one to zero", 16'h0000, 1'b1, 1'b1);
        tick();
        chk0("second en", 16'h0000, 1'b1, 1'b0);
        chk1("second en", 16'h9959, 1'b0, 1'b0);
        chk("tc wrap nonzero", 32'(bus1.tc), 32'd0);
        drive(1'b1, 1'b0, 16'h0000);
        #1;
        chk("tc en low", 32'(bus0.tc), 32'd0);
        tick();
        chk1("wrap idle", 16'h9959, 1'b0, 1'b0);

        // load beats en in the same cycle
        drive(1'b0, 1'b1, 16'h0005);
        tick();
        chk0("load beats en", 16'h0005, 1'b0, 1'b0);
        chk1("load beats en", 16'h0005, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0000);
        tick();
        chk0("dec after load", 16'h0004, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        chk0("idle hold", 16'h0004, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
